dct_block_ctrl: RTL and testbench

DCT_BLOCK_CTRL -- requirements
Module: dct_block_ctrl

---
 rtl/dct_block_ctrl.sv | 103 ++++++++++
 tb/tb_dct_block_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dct_block_ctrl.sv
// Block controller for an 8-point DCT: collects eight EEG samples, runs the lanes
// for COMPUTE_CYCLES, then streams the eight coefficients out. Optional block counter under DCT_BLOCK_CTRL_BLKCNT_EN.
module dct_block_ctrl #(
  parameter int unsigned COMPUTE_CYCLES = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         s_valid,
  output logic         s_ready,
  input  logic [7:0]   s_data,
  output logic         dct_en,
  output logic         dct_cs,
  output logic [63:0]  dct_x,
  input  logic [151:0] dct_z,
  output logic         m_valid,
  input  logic         m_ready,
  output logic [18:0]  m_data,
  output logic [2:0]   m_idx,
  output logic         busy
`ifdef DCT_BLOCK_CTRL_BLKCNT_EN
  ,
  output logic [15:0]  blk_cnt
`endif
);

  // Handshakes: a sample moves on s_valid && s_ready, a coefficient on m_valid && m_ready,
  // both sampled at the rising edge; valid/data never depend on the same-side ready.
  typedef enum logic [1:0] {
    FILL    = 2'd0,
    COMPUTE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  localparam logic [7:0] CYC_LAST = 8'(COMPUTE_CYCLES - 1);

  state_t      state_q, state_d;
  logic [2:0]  wr_cnt_q;
  logic [2:0]  rd_idx_q;
  logic [7:0]  cyc_cnt_q;
  logic [63:0] x_q;
  logic [18:0] hold_q [8];

  logic accept;
  logic cyc_last;
  logic out_hs;

  // s_ready is gated by rst_n so it reads low for the whole reset pulse.
  assign s_ready  = rst_n && en && (state_q == FILL);
  assign accept   = s_valid && s_ready;
  assign cyc_last = (state_q == COMPUTE) && (cyc_cnt_q == CYC_LAST);
  assign out_hs   = (state_q == DRAIN) && m_ready;

  assign dct_en  = (state_q == COMPUTE);
  assign dct_cs  = (state_q == COMPUTE);
  assign dct_x   = x_q;
  assign m_valid = (state_q == DRAIN);
  assign m_data  = (state_q == DRAIN) ? hold_q[rd_idx_q] : '0;
  assign m_idx   = (state_q == DRAIN) ? rd_idx_q : '0;
  assign busy    = (state_q == COMPUTE) || (state_q == DRAIN);

  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (accept && (wr_cnt_q == 3'd7)) state_d = COMPUTE;
      COMPUTE: if (cyc_last) state_d = DRAIN;
      DRAIN:   if (out_hs && (rd_idx_q == 3'd7)) state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FILL;
      wr_cnt_q  <= '0;
      rd_idx_q  <= '0;
      cyc_cnt_q <= '0;
      x_q       <= '0;
      for (int k = 0; k < 8; k++) hold_q[k] <= '0;
    end else begin
      state_q <= state_d;
      // wr_cnt wraps 7->0 on the eighth accept, leaving it cleared for the next block.
      if (accept) begin
        wr_cnt_q             <= wr_cnt_q + 3'd1;
        x_q[wr_cnt_q*8 +: 8] <= s_data;
      end
      if (state_q == COMPUTE && !cyc_last) cyc_cnt_q <= cyc_cnt_q + 8'd1;
      else                                 cyc_cnt_q <= '0;
      if (cyc_last) begin
        for (int k = 0; k < 8; k++) hold_q[k] <= dct_z[19*k +: 19];
      end
      if (out_hs) rd_idx_q <= rd_idx_q + 3'd1;
    end
  end

`ifdef DCT_BLOCK_CTRL_BLKCNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                            blk_cnt <= '0;
    else if (out_hs && rd_idx_q == 3'd7)   blk_cnt <= blk_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_dct_block_ctrl.sv
// Directed bench for dct_block_ctrl: full blocks, extreme coefficients, output stall,
// enable stall during fill and reset in the middle of COMPUTE.
module tb_dct_block_ctrl;

  localparam int N = 10;

  logic         clk;
  logic         rst_n;
  logic         en;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         dct_en;
  logic         dct_cs;
  logic [63:0]  dct_x;
  logic [151:0] dct_z;
  logic         m_valid;
  logic         m_ready;
  logic [18:0]  m_data;
  logic [2:0]   m_idx;
  logic         busy;
`ifdef DCT_BLOCK_CTRL_BLKCNT_EN
  logic [15:0]  blk_cnt;
`endif

  int checks;
  int failures;
  logic [18:0] exp_q[$];

  dct_block_ctrl #(.COMPUTE_CYCLES(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (en),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .dct_en  (dct_en),
    .dct_cs  (dct_cs),
    .dct_x   (dct_x),
    .dct_z   (dct_z),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_idx   (m_idx),
    .busy    (busy)
`ifdef DCT_BLOCK_CTRL_BLKCNT_EN
    ,
    .blk_cnt (blk_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // driver: present one sample and hold it until accepted (bounded)
  task automatic send(input logic [7:0] d);
    int waited;
    waited = 0;
    s_data  = d;
    s_valid = 1'b1;
    #1;
    while (!s_ready && waited < 200) begin
      step();
      waited++;
    end
    if (!s_ready) chk("send_timeout", 64'(waited), 64'd0);
    step();
    s_valid = 1'b0;
  endtask

  // stub lane results; each written value is also the expected coefficient
  task automatic load_z(input logic [18:0] z0, input logic [18:0] z1, input logic [18:0] z2,
                        input logic [18:0] z3, input logic [18:0] z4, input logic [18:0] z5,
                        input logic [18:0] z6, input logic [18:0] z7);
    logic [18:0] zv [8];
    zv[0] = z0; zv[1] = z1; zv[2] = z2; zv[3] = z3;
    zv[4] = z4; zv[5] = z5; zv[6] = z6; zv[7] = z7;
    exp_q.delete();
    for (int k = 0; k < 8; k++) begin
      dct_z[19*k +: 19] = zv[k];
      exp_q.push_back(zv[k]);
    end
  endtask

  // called right after the eighth accept: the pulse must already be high
  task automatic wait_compute(input logic [63:0] exp_x);
    int cnt;
    cnt = 0;
    chk("x_order", dct_x, exp_x);
    chk("ready_in_compute", 64'(s_ready), 64'd0);
    while (dct_en && cnt < 300) begin
      if (!dct_cs) chk("cs_follows_en", 64'(dct_cs), 64'd1);
      cnt++;
      step();
    end
    chk("compute_len", 64'(cnt), 64'(N));
    chk("first_valid", 64'(m_valid), 64'd1);
    chk("x_held", dct_x, exp_x);
    chk("busy_drain", 64'(busy), 64'd1);
  endtask

  // scoreboard: pop expected coefficients, optional stall at one index
  task automatic drain(input int stall_at, input int stall_len);
    logic [18:0] e;
    for (int k = 0; k < 8; k++) begin
      e = exp_q.pop_front();
      if (k == stall_at) begin
        m_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          #1;
          chk("stall_idx", 64'(m_idx), 64'(k));
          chk("stall_data", 64'(m_data), 64'(e));
          chk("stall_ready", 64'(s_ready), 64'd0);
          step();
        end
        m_ready = 1'b1;
      end
      chk("m_valid", 64'(m_valid), 64'd1);
      chk("m_idx", 64'(m_idx), 64'(k));
      chk("m_data", 64'(m_data), 64'(e));
      step();
    end
    chk("back_fill_valid", 64'(m_valid), 64'd0);
    chk("back_fill_busy", 64'(busy), 64'd0);
    chk("back_fill_ready", 64'(s_ready), 64'(en));
  endtask

  initial begin
    int hi_cnt;
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    en       = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    m_ready  = 1'b1;
    dct_z    = '0;

    // reset state
    #12;
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_dct_en", 64'(dct_en), 64'd0);
    chk("rst_dct_cs", 64'(dct_cs), 64'd0);
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_m_data", 64'(m_data), 64'd0);
    chk("rst_m_idx", 64'(m_idx), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_dct_x", dct_x, 64'd0);
    step();
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 64'(s_ready), 64'd1);

    // block 1: samples 1..8, Zk = k*1000
    load_z(19'd0, 19'd1000, 19'd2000, 19'd3000, 19'd4000, 19'd5000, 19'd6000, 19'd7000);
    for (int k = 1; k <= 8; k++) send(8'(k));
    wait_compute(64'h0807060504030201);
    drain(-1, 0);

    // block 2: extreme lane values pass through bit-exactly
    load_z(19'h40000, 19'd1000, 19'd2000, 19'd3000, 19'd4000, 19'd5000, 19'd6000, 19'h3FFFF);
    send(8'h80); send(8'h7F); send(8'hFF); send(8'h00);
    send(8'h01); send(8'hFE); send(8'h55); send(8'hAA);
    wait_compute(64'hAA55FE0100FF7F80);
    drain(-1, 0);

    // block 3: downstream stalls 5 cycles at index 3
    load_z(19'd100, 19'd101, 19'd102, 19'd103, 19'd104, 19'd105, 19'd106, 19'd107);
    for (int k = 0; k < 8; k++) send(8'(8'h0A + k));
    wait_compute(64'h11100F0E0D0C0B0A);
    drain(3, 5);
`ifdef DCT_BLOCK_CTRL_BLKCNT_EN
    chk("blk_cnt_3", 64'(blk_cnt), 64'd3);
`endif

    // block 4: enable dropped for 20 cycles after four samples
    load_z(19'd1, 19'd501, 19'd1001, 19'd1501, 19'd2001, 19'd2501, 19'd3001, 19'd3501);
    send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    en      = 1'b0;
    s_data  = 8'hEE;
    s_valid = 1'b1;
    hi_cnt  = 0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (s_ready || dct_en) hi_cnt++;
      step();
    end
    s_valid = 1'b0;
    chk("en_low_stall", 64'(hi_cnt), 64'd0);
    chk("en_low_partial_x", dct_x[31:0], 64'hC4C3C2C1);
    en = 1'b1;
    send(8'hC5); send(8'hC6); send(8'hC7); send(8'hC8);
    wait_compute(64'hC8C7C6C5C4C3C2C1);
    drain(-1, 0);

    // block 5: reset at compute cycle 5 discards the block
    load_z(19'd9, 19'd9, 19'd9, 19'd9, 19'd9, 19'd9, 19'd9, 19'd9);
    for (int k = 0; k < 8; k++) send(8'(8'h21 + k));
    repeat (5) step();
    chk("pre_rst_compute", 64'(dct_en), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_dct_en", 64'(dct_en), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_x", dct_x, 64'd0);
    chk("mid_rst_ready", 64'(s_ready), 64'd0);
    step();
    rst_n  = 1'b1;
    hi_cnt = 0;
    for (int c = 0; c < 15; c++) begin
      if (m_valid || dct_en) hi_cnt++;
      step();
    end
    chk("no_partial_out", 64'(hi_cnt), 64'd0);
    load_z(19'd0, 19'd11, 19'd22, 19'd33, 19'd44, 19'd55, 19'd66, 19'd77);
    for (int k = 0; k < 8; k++) send(8'(8'h31 + k));
    wait_compute(64'h3837363534333231);
    drain(-1, 0);
`ifdef DCT_BLOCK_CTRL_BLKCNT_EN
    chk("blk_cnt_after_rst", 64'(blk_cnt), 64'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
